// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control and operands for EX,
// inserts bubbles on load-use hazards and flushes, and counts those events.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_alusrc,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic [1:0]        id_aluop,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic              ex_alusrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall_if,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Control bundle order: alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0]
    logic              valid_q, valid_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [6:0]        funct7_q, funct7_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

    logic use_rs2, hazard, load_data, take_ctrl;

    always_comb begin
        use_rs2 = !id_alusrc | id_memwrite | id_branch;
        hazard  = valid_q & ctrl_q[4] & (rd_q != 5'd0) & id_valid &
                  ((rd_q == id_rs1) | (use_rs2 & (rd_q == id_rs2)));
        stall_if = (hazard | ex_hold) & !flush;
        // Datapath moves on every edge except a pure hold; control only on a clean load.
        load_data = flush | !ex_hold;
        take_ctrl = !flush & !ex_hold & !hazard & id_valid;
    end

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        pc_d         = pc_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        funct3_d     = funct3_q;
        funct7_d     = funct7_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (load_data) begin
            valid_d  = take_ctrl;
            ctrl_d   = take_ctrl ? {id_alusrc, id_memtoreg, id_regwrite, id_memread,
                                    id_memwrite, id_branch, id_aluop} : 8'd0;
            pc_d     = id_pc;
            rd1_d    = id_rd1;
            rd2_d    = id_rd2;
            imm_d    = id_imm;
            rs1_d    = id_rs1;
            rs2_d    = id_rs2;
            rd_d     = id_rd;
            funct3_d = id_funct3;
            funct7_d = id_funct7;
        end
        if (flush && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
        if (!flush && !ex_hold && hazard && !(&bubble_cnt_q))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            pc_q         <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            funct3_q     <= '0;
            funct7_q     <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            pc_q         <= pc_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            funct3_q     <= funct3_d;
            funct7_q     <= funct7_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_alusrc   = ctrl_q[7];
    assign ex_memtoreg = ctrl_q[6];
    assign ex_regwrite = ctrl_q[5];
    assign ex_memread  = ctrl_q[4];
    assign ex_memwrite = ctrl_q[3];
    assign ex_branch   = ctrl_q[2];
    assign ex_aluop    = ctrl_q[1:0];
    assign ex_pc       = pc_q;
    assign ex_rd1      = rd1_q;
    assign ex_rd2      = rd2_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7   = funct7_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; counters built 2 bits wide so saturation is reachable.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 9;
    localparam int CNT_W  = 2;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
    logic [1:0] id_aluop;
    logic [PC_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [2:0] id_funct3;
    logic [6:0] id_funct7;
    logic flush, ex_hold;
    logic ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0] ex_aluop;
    logic [PC_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_funct3;
    logic [6:0] ex_funct7;
    logic stall_if;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop(id_aluop), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .stall_if(stall_if),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // valid, {alusrc,memtoreg,regwrite,memread,memwrite,branch}, aluop, rs1, rs2, rd, pc, imm
    task automatic set_id(input logic v, input logic [5:0] c, input logic [1:0] op,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic [8:0] pc, input logic [31:0] imm);
        id_valid = v;
        {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch} = c;
        id_aluop = op;
        id_rs1 = s1;
        id_rs2 = s2;
        id_rd = d;
        id_pc = pc;
        id_imm = imm;
        id_rd1 = 32'h1000_0000 | {23'd0, pc};
        id_rd2 = 32'h2000_0000 | {23'd0, pc};
        id_funct3 = pc[2:0];
        id_funct7 = pc[6:0];
    endtask

    function automatic logic [7:0] ex_ctrl();
        return {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop};
    endfunction

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        ex_hold = 1'b0;
        set_id(1'($urandom), 6'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 9'($urandom), $urandom);
        tick(); tick(); tick();
        check("rst_valid", {31'd0, ex_valid}, 0);
        check("rst_ctrl", {24'd0, ex_ctrl()}, 0);
        check("rst_pc", {23'd0, ex_pc}, 0);
        check("rst_rd1", ex_rd1, 0);
        check("rst_imm", ex_imm, 0);
        check("rst_rd", {27'd0, ex_rd}, 0);
        check("rst_stall", {31'd0, stall_if}, 0);
        check("rst_bcnt", {30'd0, bubble_cnt}, 0);
        check("rst_fcnt", {30'd0, flush_cnt}, 0);
        reset = 1'b1;

        // normal pass: add x6,x5,x1
        set_id(1, 6'b001000, 2'b10, 5, 1, 6, 9'h010, 32'h0);
        #1 check("norm_stall_pre", {31'd0, stall_if}, 0);
        tick();
        check("norm_valid", {31'd0, ex_valid}, 1);
        check("norm_ctrl", {24'd0, ex_ctrl()}, 32'b0010_0010);
        check("norm_pc", {23'd0, ex_pc}, 32'h010);
        check("norm_rd1", ex_rd1, 32'h1000_0010);
        check("norm_rd2", ex_rd2, 32'h2000_0010);
        check("norm_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, 5'd5, 5'd1, 5'd6});
        check("norm_f3f7", {22'd0, ex_funct3, ex_funct7}, {22'd0, 3'h0, 7'h10});
        check("norm_stall", {31'd0, stall_if}, 0);

        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        set_id(1, 6'b111100, 2'b00, 2, 0, 5, 9'h014, 32'd4);
        tick();
        check("lu_ex_memread", {31'd0, ex_memread}, 1);
        set_id(1, 6'b001000, 2'b10, 5, 1, 6, 9'h018, 32'h0);
        #1 check("lu_stall", {31'd0, stall_if}, 1);
        tick();
        check("lu_bub_valid", {31'd0, ex_valid}, 0);
        check("lu_bub_ctrl", {24'd0, ex_ctrl()}, 0);
        check("lu_bub_rd", {27'd0, ex_rd}, 6);
        check("lu_bcnt", {30'd0, bubble_cnt}, 1);
        check("lu_stall_drop", {31'd0, stall_if}, 0);
        tick();
        check("lu_load_valid", {31'd0, ex_valid}, 1);
        check("lu_load_ctrl", {24'd0, ex_ctrl()}, 32'b0010_0010);
        check("lu_load_pc", {23'd0, ex_pc}, 32'h018);
        check("lu_stall_after", {31'd0, stall_if}, 0);

        // case A: lw x0 in EX, ID reads x0
        set_id(1, 6'b111100, 2'b00, 2, 0, 0, 9'h020, 32'd8);
        tick();
        set_id(1, 6'b001000, 2'b10, 0, 0, 6, 9'h024, 32'h0);
        #1 check("nfs_a_stall", {31'd0, stall_if}, 0);
        // case B: lw x5, then addi x6,x7,1 whose rs2 field happens to be 5
        tick();
        set_id(1, 6'b111100, 2'b00, 2, 0, 5, 9'h028, 32'd12);
        tick();
        set_id(1, 6'b101000, 2'b00, 7, 5, 6, 9'h02c, 32'd1);
        #1 check("nfs_b_stall", {31'd0, stall_if}, 0);
        tick();
        check("nfs_b_load", {31'd0, ex_alusrc, ex_valid}, 32'b11);
        check("nfs_b_bcnt", {30'd0, bubble_cnt}, 1);

        // hold with hazard pending, then flush wins over hold
        set_id(1, 6'b111100, 2'b00, 2, 0, 5, 9'h030, 32'd16);
        tick();
        set_id(1, 6'b001000, 2'b10, 5, 1, 6, 9'h034, 32'h0);
        ex_hold = 1'b1;
        #1 check("hold_stall", {31'd0, stall_if}, 1);
        tick();
        check("hold1_ex", {14'd0, ex_valid, ex_memread, ex_rd, ex_pc}, {14'd0, 2'b11, 5'd5, 9'h030});
        tick();
        check("hold2_ex", {14'd0, ex_valid, ex_memread, ex_rd, ex_pc}, {14'd0, 2'b11, 5'd5, 9'h030});
        check("hold_imm", ex_imm, 32'd16);
        check("hold_stall2", {31'd0, stall_if}, 1);
        flush = 1'b1;
        #1 check("flush_stall", {31'd0, stall_if}, 0);
        tick();
        check("flush_valid", {31'd0, ex_valid}, 0);
        check("flush_ctrl", {24'd0, ex_ctrl()}, 0);
        check("flush_pc", {23'd0, ex_pc}, 32'h034);
        check("flush_fcnt", {30'd0, flush_cnt}, 1);
        check("flush_bcnt", {30'd0, bubble_cnt}, 1);
        flush = 1'b0;
        ex_hold = 1'b0;

        // reset mid-stall
        set_id(1, 6'b111100, 2'b00, 2, 0, 5, 9'h040, 32'd20);
        tick();
        set_id(1, 6'b001000, 2'b10, 5, 1, 6, 9'h044, 32'h0);
        #1 check("mid_stall_pre", {31'd0, stall_if}, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall_if}, 0);
        check("mid_rst_valid", {31'd0, ex_valid}, 0);
        check("mid_rst_cnt", {28'd0, bubble_cnt, flush_cnt}, 0);
        tick();
        reset = 1'b1;

        // saturation with 2-bit counters
        flush = 1'b1;
        tick(); check("sat_1", {30'd0, flush_cnt}, 1);
        tick(); check("sat_2", {30'd0, flush_cnt}, 2);
        tick(); check("sat_3", {30'd0, flush_cnt}, 3);
        tick(); check("sat_4", {30'd0, flush_cnt}, 3);
        tick(); check("sat_5", {30'd0, flush_cnt}, 3);
        check("sat_bcnt", {30'd0, bubble_cnt}, 0);
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core; sits directly downstream of the instruction decoder/control unit.
- Captures decoded control bits plus operands and register indices for the EX stage.
- Detects load-use hazards, inserts bubbles, and applies branch flushes.
- Keeps saturating bubble/flush event counters for debug.

Parameters:
- DATA_W, 32, width of register-file operands and immediate.
- PC_W, 9, width of program counter.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoded control bits.
- id_aluop  in  2  decoded ALU operation class.
- id_pc  in  PC_W  PC of the ID instruction.
- id_rd1, id_rd2, id_imm  in  DATA_W  operand 1, operand 2, sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_funct3  in  3  instruction funct3 field.
- id_funct7  in  7  instruction funct7 field.
- flush  in  1  branch taken in a later stage; kill the ID instruction.
- ex_hold  in  1  downstream stall; freeze this register.
- ex_valid  out  1  EX stage holds a real instruction.
- ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  registered control bits.
- ex_aluop  out  2  registered ALU operation class.
- ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7  out  as inputs  registered datapath fields.
- stall_if  out  1  combinational; freeze PC and IF/ID this cycle.
- bubble_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered outputs go to 0, including ex_valid and both counters.
  - stall_if evaluates to 0, since ex_valid=0.
- Hazard term (combinational):
  - use_rs2 = !id_alusrc | id_memwrite | id_branch.
  - hazard = ex_valid & ex_memread & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (use_rs2 & ex_rd==id_rs2)).
- stall_if = (hazard | ex_hold) & !flush.
- Per rising edge, mutually exclusive, in this priority order:
  1. flush=1: BUBBLE. flush_cnt increments. Applies even when ex_hold=1.
  2. ex_hold=1: HOLD. Every register and both counters keep their value.
  3. hazard=1: BUBBLE. bubble_cnt increments.
  4. Otherwise: LOAD. All ex_* fields take their id_* inputs; ex_valid <= id_valid.
- BUBBLE definition:
  - ex_valid and all control outputs (alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop) go to 0.
  - Datapath fields (pc, rd1, rd2, imm, rs1, rs2, rd, funct3, funct7) still load from the id_* inputs, so state stays deterministic.
- LOAD with id_valid=0: control bits force to 0, exactly as in a bubble; counters unchanged.
- Latency: one cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly one cycle. After the bubble, ex_memread=0 so hazard drops and the held ID instruction loads on the next edge.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-stall: all outputs clear immediately; stall_if drops in the same cycle.

Test Plan:
- Reset:
  - Drive random inputs, then assert reset=0 for 3 cycles.
  - Required: all ex_* = 0, ex_valid=0, stall_if=0, bubble_cnt=flush_cnt=0.
- Normal pass:
  - ID presents add x6,x5,x1 (regwrite=1, aluop=2'b10, rs1=5, rs2=1, rd=6, pc=9'h010), id_valid=1.
  - Required: after one edge, ex_* match the inputs, ex_valid=1, stall_if=0.
- Load-use:
  - EX holds lw x5 (memread=1, rd=5); ID holds add x6,x5,x1.
  - Required: stall_if=1 for one cycle; next edge ex_valid=0 with control zero; bubble_cnt=1; following edge the add loads and stall_if=0.
- No false stall:
  - Case A: EX lw with rd=0 and ID rs1=0 -> stall_if=0.
  - Case B: EX lw rd=5, ID addi x6,x7,1 with alusrc=1 and rs2 field=5 -> stall_if=0.
- Flush vs hold:
  - ex_hold=1 for 2 cycles: ex_* stable, stall_if=1.
  - Then flush=1 together with ex_hold=1 and a hazard present: stall_if=0, next edge ex_valid=0, flush_cnt=1, bubble_cnt unchanged.
- Saturation:
  - Set CNT_W=2 and issue 5 consecutive flushes.
  - Required: flush_cnt reads 1,2,3,3,3.
